input_port: RTL and testbench

Front-end for the CPU's switch/button input path. Synchronises the raw board button and switches, debounces the button, and captures one switch word per press into a small FIFO. Presents the words to the CPU through a valid/ready handshake, so presses made while the CPU is busy are not lost. Sits between the board pins and the CPU `in`/`control` inputs, clocked from the divided system clock.

---
 rtl/input_port.sv | 138 +++++++++++++
 tb/tb_input_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_port.sv
// input_port: button/switch front-end. Synchronises btn/sw, debounces the button,
// captures one switch word per press into a FIFO presented via valid/ready.
// Build option: define INPUT_PORT_DEBOUNCE_EN to include the stability-counter debouncer;
// otherwise btn_db follows the synchronised button every cycle.
module input_port #(
  parameter int unsigned DATA_WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn,
  input  logic [DATA_WIDTH-1:0]         sw,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic                  btn_m_q, btn_s_q;
  logic [DATA_WIDTH-1:0] sw_m_q, sw_s_q;
  logic                  btn_db_q, btn_db_d;
  logic [1:0]            fill_q;
  logic                  armed_q, armed_d;
  logic                  push_q, rise;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q;
  logic                  full, pop, do_push;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
      sw_m_q  <= '0;
      sw_s_q  <= '0;
    end else begin
      btn_m_q <= btn;
      btn_s_q <= btn_m_q;
      sw_m_q  <= sw;
      sw_s_q  <= sw_m_q;
    end
  end

`ifdef INPUT_PORT_DEBOUNCE_EN
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  // Debounced value only follows btn_s after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Stability counter register
  always_ff @(posedge clk) begin
    if (!rst_n) db_cnt_q <= '0;
    else        db_cnt_q <= db_cnt_d;
  end
`else
  assign btn_db_d = btn_s_q;
`endif

  // Arm only once the synchronisers have refilled after reset and the button reads released,
  // so a button held through reset never produces an event.
  assign armed_d = armed_q | (fill_q[1] & ~btn_s_q & ~btn_db_q);
  assign rise    = btn_db_d & ~btn_db_q & armed_q;

  // Debounced button, arming state, press pulse and captured word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
      fill_q   <= 2'b00;
      armed_q  <= 1'b0;
      push_q   <= 1'b0;
      wdata_q  <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      fill_q   <= {fill_q[0], 1'b1};
      armed_q  <= armed_d;
      push_q   <= rise;
      if (rise) wdata_q <= sw_s_q;
    end
  end

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge
  assign do_push  = push_q & (~full | pop);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  // Occupancy next state
  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push_q && full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_port.sv
module tb_input_port;

`ifdef INPUT_PORT_DEBOUNCE_EN
  localparam int EffD = 8;
`else
  localparam int EffD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [3:0] sw;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic [2:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  input_port #(
    .DATA_WIDTH(4),
    .FIFO_DEPTH(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .sw(sw),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after each rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: each accepted head word is compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    tick(4);
  endtask

  // Press and hold until the word is written, optionally popping on the write edge
  task automatic press(input logic [3:0] v, input bit pop_on_write);
    sw  = v;
    btn = 1'b1;
    tick(2 + EffD);
    if (pop_on_write) rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    btn = 1'b0;
    tick(EffD + 4);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre_events;
    int n_highs;
    rst_n = 1'b0; btn = 1'b1; sw = 4'h0; rd_ready = 1'b0;

    // Reset with the button held
    tick(2);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(EffD + 8);
    chk("held_no_push", 32'(count), 0);
    btn = 1'b0;
    tick(EffD + 4);
    exp_q.push_back(4'h3);
    press(4'h3, 1'b0);
    chk("repress_count", 32'(count), 1);
    drain(1);
    chk("repress_drained", 32'(count), 0);

    // Single press latency
    sw  = 4'hA;
    btn = 1'b1;
    exp_q.push_back(4'hA);
    tick(2 + EffD);
    chk("lat_not_yet", 32'(rd_valid), 0);
    tick(1);
    chk("lat_valid", 32'(rd_valid), 1);
    chk("lat_data", 32'(rd_data), 32'h A);
    chk("lat_count", 32'(count), 1);
    btn = 1'b0;
    tick(EffD + 4);
    drain(1);
    chk("pop_valid", 32'(rd_valid), 0);
    chk("pop_count", 32'(count), 0);

    // Bounce: 3-cycle toggles, then a steady hold
    n_highs    = (EffD > 1) ? 5 : 2;
    pre_events = (EffD > 1) ? 0 : n_highs;
    sw = 4'h6;
    for (int i = 0; i <= pre_events; i++) exp_q.push_back(4'h6);
    for (int i = 0; i < n_highs; i++) begin
      btn = 1'b1; tick(3);
      btn = 1'b0; tick(3);
    end
    chk("bounce_short", 32'(count), 32'(pre_events));
    btn = 1'b1;
    tick(3 + EffD);
    chk("bounce_hold", 32'(count), 32'(pre_events + 1));
    btn = 1'b0;
    tick(EffD + 4);
    drain(pre_events + 1);
    chk("bounce_drained", 32'(count), 0);

    // Fill and overflow
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(4'(v));
      press(4'(v), 1'b0);
    end
    chk("full_count", 32'(count), 4);
    chk("full_no_ovf", 32'(overflow), 0);
    press(4'h5, 1'b0);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_set", 32'(overflow), 1);
    drain(4);
    chk("ovf_drained", 32'(rd_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    do_reset();
    chk("ovf_cleared", 32'(overflow), 0);

    // Push and pop together, not full
    exp_q.push_back(4'h1);
    press(4'h1, 1'b0);
    exp_q.push_back(4'h2);
    press(4'h2, 1'b1);
    chk("pushpop_count", 32'(count), 1);
    drain(1);

    // Push and pop together while full; pointers wrap
    for (int v = 7; v <= 10; v++) begin
      exp_q.push_back(4'(v));
      press(4'(v), 1'b0);
    end
    exp_q.push_back(4'hB);
    press(4'hB, 1'b1);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_no_ovf", 32'(overflow), 0);
    drain(4);
    chk("fullpp_drained", 32'(rd_valid), 0);

    // Reset mid-operation with a press in flight
    exp_q.push_back(4'h5);
    press(4'h5, 1'b0);
    exp_q.push_back(4'hC);
    press(4'hC, 1'b0);
    sw  = 4'h7;
    btn = 1'b1;
    tick(EffD);
    btn = 1'b0;
    do_reset();
    tick(EffD + 6);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(rd_valid), 0);
    chk("midrst_data", 32'(rd_data), 0);

    // One-cycle pulse: an event only without the debouncer
    sw  = 4'h9;
    btn = 1'b1;
    if (EffD == 1) exp_q.push_back(4'h9);
    tick(1);
    btn = 1'b0;
    tick(2);
    chk("pulse_not_yet", 32'(rd_valid), 0);
    tick(1);
    chk("pulse_valid", 32'(rd_valid), (EffD == 1) ? 1 : 0);
    chk("pulse_count", 32'(count), (EffD == 1) ? 1 : 0);
    tick(EffD + 4);
    drain((EffD == 1) ? 1 : 0);

    tick(2);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
